dmem_responder: RTL and testbench

Data-memory responder for the MEM stage of the pipelined ARM-subset core. Accepts one load/store request at a time from the EX/MEM-side initiator, inserts a fixed number of wait states, then completes with a single-cycle `ready` pulse. Read data is returned on `rdata`. Storage is byte-addressed and big-endian, with the same byte ordering as the instruction ROM. Word and byte sizes are supported.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 45 ++++
 rtl/dmem_responder.sv | 195 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The state enum, the access encodings and the byte-enable helper live here
// so the top level and any checker bound to it agree on one encoding.
package dmem_pkg;

  // Responder FSM states; encoding is visible on the fsm_state debug port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Access size encodings on the size input.
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  // Access type encodings on the rw input.
  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  // Byte-lane enables for a store. Lane 0 is the byte at the base address
  // (most significant byte of the word, big-endian), lane 3 is base+3.
  function automatic logic [3:0] byte_enables(input logic size);
    byte_enables = (size == SIZE_BYTE) ? 4'b0001 : 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-wide data storage for the responder.
// One synchronous write port with four byte-lane enables and one
// combinational four-byte big-endian read port. Both ports work from the
// same base address; the four byte indices wrap modulo DEPTH so a word
// near the top of storage continues at byte 0.
// Contents have no reset: they survive a responder reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Index width; DEPTH is a power of two so truncating the sum wraps it.
  localparam int IW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [IW-1:0] idx [4];

  // Byte indices for lanes 0..3, wrapped modulo DEPTH.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i] = addr[IW-1:0] + IW'(i);
    end
  end

  // Byte-enabled write; lane i takes wdata byte (3-i), i.e. MSB at base.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[idx[i]] <= wdata[31-8*i -: 8];
      end
    end
  end

  // Big-endian word read starting at the wrapped base address.
  always_comb begin
    rdata = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// Accepts one load/store at a time, spends WAIT_STATES cycles in WAIT, then
// completes with a one-cycle ready pulse in RESP. Stores commit and load
// data is registered on the edge that enters RESP.
//
// Handshake: req is sampled only in IDLE. A request is accepted on any
// rising edge where the FSM is IDLE and req is high; the request fields are
// latched on that edge and all inputs are ignored while busy is high.
// ready is high for exactly the RESP cycle; rdata and err are registered
// and stable throughout it. A req held high through RESP is taken at the
// earliest on the following IDLE cycle.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When defined, a word access
// with addr[1:0] != 0 completes with err = 1, no storage write and rdata = 0.
// When undefined, word addresses are forced to a 4-byte boundary and err
// stays 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          rw,
  input  logic          size,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          ready,
  output logic          busy,
  output logic          err,
  output logic [1:0]    fsm_state
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;

  // Request fields captured at acceptance.
  logic          lat_rw;
  logic          lat_size;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;

  // Fields of the access in flight. With zero wait states the commit edge
  // is the acceptance edge itself, so in IDLE the live inputs are used.
  logic          cur_rw;
  logic          cur_size;
  logic [AW-1:0] cur_addr;
  logic [31:0]   cur_wdata;

  logic          accept;
  logic          enter_resp;
  logic          misaligned;
  logic [AW-1:0] eff_addr;
  logic [3:0]    arr_we;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;

  assign accept = (state == IDLE) && req;

  // Commit point: the edge that moves the FSM into RESP.
  assign enter_resp = (state == IDLE && req && WAIT_STATES == 0) ||
                      (state == WAIT && cnt <= 4'd1);

  // Select live inputs while idle, latched fields once the access is owned.
  always_comb begin
    if (state == IDLE) begin
      cur_rw    = rw;
      cur_size  = size;
      cur_addr  = addr;
      cur_wdata = wdata;
    end else begin
      cur_rw    = lat_rw;
      cur_size  = lat_size;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Misaligned word accesses are flagged and suppressed.
  assign misaligned = (cur_size == SIZE_WORD) && (cur_addr[1:0] != 2'b00);
  assign eff_addr   = cur_addr;
`else
  // Word accesses silently align down to a 4-byte boundary.
  assign misaligned = 1'b0;
  assign eff_addr   = (cur_size == SIZE_WORD) ? {cur_addr[AW-1:2], 2'b00}
                                              : cur_addr;
`endif

  // Byte stores place their data in lane 0 (the byte at the base address).
  assign arr_wdata = (cur_size == SIZE_BYTE) ? {cur_wdata[7:0], 24'h0}
                                             : cur_wdata;

  // Write only on a live commit edge; a reset edge discards the store.
  assign arr_we = (enter_resp && reset && cur_rw == RW_STORE && !misaligned)
                  ? byte_enables(cur_size) : 4'b0000;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (eff_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    ready     = (state == RESP);
    busy      = (state != IDLE);
    fsm_state = state;
  end

  // Wait-state counter: loaded on acceptance, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= WAIT_LOAD;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request latches, captured on the acceptance edge only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_rw    <= RW_LOAD;
      lat_size  <= SIZE_WORD;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_rw    <= rw;
      lat_size  <= size;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end
  end

  // Completion registers: load data and error flag set entering RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (enter_resp) begin
      err <= misaligned;
      if (misaligned) begin
        rdata <= '0;
      end else if (cur_rw == RW_LOAD) begin
        rdata <= (cur_size == SIZE_BYTE) ? {24'h0, arr_rdata[31:24]}
                                         : arr_rdata;
      end
    end else if (state == RESP) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance u_dut uses two wait states,
// u_dut_zw uses zero wait states. Build with +define+DMEM_ALIGN_CHECK_EN
// to exercise the alignment-check variant.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic        req_a, rw_a, size_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        ready_a, busy_a, err_a;
  logic [1:0]  st_a;

  logic        req_b, rw_b, size_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic        ready_b, busy_b, err_b;
  logic [1:0]  st_b;

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, required finish");
    $fatal(1, "time limit");
  end

  dmem_responder #(.DEPTH(256), .AW(8), .WAIT_STATES(2)) u_dut (
    .clk(clk), .reset(reset), .req(req_a), .rw(rw_a), .size(size_a),
    .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a),
    .busy(busy_a), .err(err_a), .fsm_state(st_a)
  );

  dmem_responder #(.DEPTH(256), .AW(8), .WAIT_STATES(0)) u_dut_zw (
    .clk(clk), .reset(reset), .req(req_b), .rw(rw_b), .size(size_b),
    .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b),
    .busy(busy_b), .err(err_b), .fsm_state(st_b)
  );

  // Driver: issue one access, scramble inputs while busy, wait for ready
  // (bounded), then wait for the edge that leaves RESP.
  task automatic do_access(input int which, input logic rw, input logic size,
                           input logic [7:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er,
                           output int lat, output logic got);
    @(negedge clk);
    if (which == 0) begin
      req_a = 1'b1; rw_a = rw; size_a = size; addr_a = addr; wdata_a = wdata;
    end else begin
      req_b = 1'b1; rw_b = rw; size_b = size; addr_b = addr; wdata_b = wdata;
    end
    @(posedge clk); #1;
    if (which == 0) begin
      req_a = 1'b0; rw_a = ~rw; size_a = ~size;
      addr_a = 8'($urandom_range(0, 255)); wdata_a = $urandom;
    end else begin
      req_b = 1'b0; rw_b = ~rw; size_b = ~size;
      addr_b = 8'($urandom_range(0, 255)); wdata_b = $urandom;
    end
    lat = 1; got = 1'b0; rd = '0; er = 1'b0;
    while (lat <= 20 && !got) begin
      if ((which == 0) ? ready_a : ready_b) begin
        got = 1'b1;
        rd  = (which == 0) ? rdata_a : rdata_b;
        er  = (which == 0) ? err_a : err_b;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ready_a !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b required 0", ready_a); end
    tests_run++;
    if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy_a); end
    tests_run++;
    if (err_a !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b required 0", err_a); end
    tests_run++;
    if (rdata_a !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h required 00000000", rdata_a); end
    tests_run++;
    if (st_a !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d required %0d", st_a, IDLE); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat; logic got;
    do_access(0, RW_STORE, SIZE_WORD, 8'h10, 32'hDEADBEEF, rd, er, lat, got);
    tests_run++;
    if (got !== 1'b1 || lat != 3) begin tests_failed++; $display("FAIL word_store_latency: got ready=%b lat=%0d required ready=1 lat=3", got, lat); end
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b0) begin tests_failed++; $display("FAIL word_store_rdata: got rdata=%h err=%b required 00000000 err=0", rd, er); end
    do_access(0, RW_LOAD, SIZE_WORD, 8'h10, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'hDEADBEEF || lat != 3) begin tests_failed++; $display("FAIL word_load: got %h lat=%0d required deadbeef lat=3", rd, lat); end
    do_access(0, RW_LOAD, SIZE_BYTE, 8'h10, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h000000DE) begin tests_failed++; $display("FAIL byte_load_10: got %h required 000000de", rd); end
    do_access(0, RW_LOAD, SIZE_BYTE, 8'h13, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h000000EF) begin tests_failed++; $display("FAIL byte_load_13: got %h required 000000ef", rd); end
    do_access(0, RW_STORE, SIZE_WORD, 8'h40, 32'h01010101, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h000000EF) begin tests_failed++; $display("FAIL store_keeps_rdata: got %h required 000000ef", rd); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat; logic got;
    do_access(0, RW_STORE, SIZE_WORD, 8'h20, 32'h11223344, rd, er, lat, got);
    do_access(0, RW_STORE, SIZE_BYTE, 8'h21, 32'hFFFFFFA5, rd, er, lat, got);
    do_access(0, RW_LOAD, SIZE_WORD, 8'h20, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h11A53344) begin tests_failed++; $display("FAIL byte_merge_word: got %h required 11a53344", rd); end
    do_access(0, RW_LOAD, SIZE_BYTE, 8'h21, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h000000A5) begin tests_failed++; $display("FAIL byte_load_21: got %h required 000000a5", rd); end
  endtask

  task automatic test_back_to_back();
    logic rdy [12];
    logic bsy [12];
    logic [31:0] last_rd;
    int pulses, first, second, run, max_run;
    last_rd = '0;
    @(negedge clk);
    req_a = 1'b1; rw_a = RW_LOAD; size_a = SIZE_WORD; addr_a = 8'h20;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      rdy[k] = ready_a;
      bsy[k] = busy_a;
      if (ready_a) last_rd = rdata_a;
      if (k == 7) req_a = 1'b0;
    end
    pulses = 0; first = -1; second = -1; run = 0; max_run = 0;
    for (int k = 0; k < 12; k++) begin
      if (rdy[k]) begin
        pulses++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (k < 8) begin
        run = bsy[k] ? 0 : run + 1;
        if (run > max_run) max_run = run;
      end
    end
    tests_run++;
    if (pulses != 2) begin tests_failed++; $display("FAIL b2b_pulses: got %0d required 2", pulses); end
    tests_run++;
    if (first != 2 || second != 6) begin tests_failed++; $display("FAIL b2b_spacing: got first=%0d second=%0d required 2 and 6", first, second); end
    tests_run++;
    if (max_run != 1) begin tests_failed++; $display("FAIL b2b_busy_gap: got %0d required 1", max_run); end
    tests_run++;
    if (last_rd !== 32'h11A53344) begin tests_failed++; $display("FAIL b2b_rdata: got %h required 11a53344", last_rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat; logic got;
    do_access(0, RW_STORE, SIZE_WORD, 8'h00, 32'h01020304, rd, er, lat, got);
    do_access(0, RW_STORE, SIZE_WORD, 8'h02, 32'hAABBCCDD, rd, er, lat, got);
`ifdef DMEM_ALIGN_CHECK_EN
    tests_run++;
    if (er !== 1'b1 || lat != 3) begin tests_failed++; $display("FAIL misaligned_err: got err=%b lat=%0d required err=1 lat=3", er, lat); end
    do_access(0, RW_LOAD, SIZE_WORD, 8'h00, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h01020304) begin tests_failed++; $display("FAIL misaligned_old_data: got %h required 01020304", rd); end
`else
    tests_run++;
    if (er !== 1'b0 || lat != 3) begin tests_failed++; $display("FAIL misaligned_err: got err=%b lat=%0d required err=0 lat=3", er, lat); end
    do_access(0, RW_LOAD, SIZE_WORD, 8'h00, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'hAABBCCDD) begin tests_failed++; $display("FAIL misaligned_forced: got %h required aabbccdd", rd); end
    do_access(0, RW_LOAD, SIZE_WORD, 8'h03, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'hAABBCCDD) begin tests_failed++; $display("FAIL misaligned_load: got %h required aabbccdd", rd); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic got;
    logic seen;
    do_access(0, RW_STORE, SIZE_WORD, 8'h30, 32'h0BADCAFE, rd, er, lat, got);
    do_access(0, RW_STORE, SIZE_WORD, 8'h34, 32'h55667788, rd, er, lat, got);
    @(negedge clk);
    req_a = 1'b1; rw_a = RW_STORE; size_a = SIZE_WORD; addr_a = 8'h30; wdata_a = 32'h12345678;
    @(posedge clk); #1;
    req_a = 1'b0;
    tests_run++;
    if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before: got %b required 1", busy_a); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (busy_a !== 1'b0 || ready_a !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_idle: got busy=%b ready=%b required 0 0", busy_a, ready_a); end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ready_a) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL mid_no_ready: got %b required 0", seen); end
    do_access(0, RW_LOAD, SIZE_WORD, 8'h30, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h0BADCAFE) begin tests_failed++; $display("FAIL mid_prior_value: got %h required 0badcafe", rd); end
    do_access(0, RW_LOAD, SIZE_WORD, 8'h34, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h55667788) begin tests_failed++; $display("FAIL mid_neighbour: got %h required 55667788", rd); end
  endtask

  task automatic test_wrap_zero_wait();
    logic [31:0] rd; logic er; int lat; logic got;
    do_access(1, RW_STORE, SIZE_WORD, 8'hFC, 32'hCAFEF00D, rd, er, lat, got);
    tests_run++;
    if (got !== 1'b1 || lat != 1) begin tests_failed++; $display("FAIL zw_store_latency: got ready=%b lat=%0d required ready=1 lat=1", got, lat); end
    do_access(1, RW_LOAD, SIZE_BYTE, 8'hFF, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'h0000000D) begin tests_failed++; $display("FAIL zw_byte_ff: got %h required 0000000d", rd); end
    do_access(1, RW_LOAD, SIZE_WORD, 8'hFC, 32'h0, rd, er, lat, got);
    tests_run++;
    if (rd !== 32'hCAFEF00D || lat != 1) begin tests_failed++; $display("FAIL zw_word_load: got %h lat=%0d required cafef00d lat=1", rd, lat); end
    tests_run++;
    if (st_b !== IDLE || busy_b !== 1'b0) begin tests_failed++; $display("FAIL zw_idle_after: got state=%0d busy=%b required 0 0", st_b, busy_b); end
  endtask

  initial begin
    reset = 1'b0;
    req_a = 1'b0; rw_a = 1'b0; size_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; rw_b = 1'b0; size_b = 1'b0; addr_b = '0; wdata_b = '0;
    test_reset();
    test_word();
    test_byte();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    test_wrap_zero_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
